seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl.sv | 114 +++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed seven-segment scan controller with frame-synchronous double-buffered load.
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   enable      in   1 = scanning runs, 0 = display dark and scan held at digit 0
//   digit_mask  in   [3:0] per-digit lit enable, bit i drives anode[i]
//   load_data   in   [15:0] display value, digit i = load_data[4i+3:4i]
//   load_valid  in   load request
//   load_ready  out  pending buffer empty, a load is accepted this cycle
//   anode       out  [3:0] active-low digit select
//   seg         out  [6:0] active-low cathodes {g,f,e,d,c,b,a}
//   digit_sel   out  [1:0] index of the digit currently driven
//   frame_done  out  one-cycle pulse after each frame boundary
// Optional macro SEG_GHOST_BLANK_EN: blank all anodes for the first BLANK_CYCLES cycles of each slot.
module seven_seg_scan_ctrl #(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [3:0]  digit_mask,
   input  logic [15:0] load_data,
   input  logic        load_valid,
   output logic        load_ready,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic [1:0]  digit_sel,
   output logic        frame_done
);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
`ifdef SEG_GHOST_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   typedef enum logic [1:0] {D0, D1, D2, D3} scan_t;
   scan_t idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] active_q, active_d, shadow_q, shadow_d;
   logic pending_q, pending_d;
   logic [3:0] anode_q, anode_d;
   logic [6:0] seg_q, seg_d;
   logic [1:0] digit_sel_q, digit_sel_d;
   logic frame_done_q, frame_done_d;
   logic tick, boundary, xfer, accept, blank;
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction
   always_comb begin
      tick = enable && (cnt_q == CNT_LAST);
      boundary = tick && (idx_q == D3);
      // while disabled there is no frame in progress, so a pending value may land at once
      xfer = pending_q && (boundary || !enable);
      accept = load_valid && !pending_q;
      cnt_d = (enable && !tick) ? cnt_q + 1'b1 : '0;
      idx_d = !enable ? D0 : tick ? scan_t'(idx_q + 2'd1) : idx_q;
      active_d = xfer ? shadow_q : active_q;
      shadow_d = accept ? load_data : shadow_q;
      pending_d = accept || (pending_q && !xfer);
      blank = BLANK_EN && (cnt_d < CNT_BLANK);
      // outputs follow next-state values so digit and data switch on the same edge as idx
      anode_d = (enable && !blank) ? ~(digit_mask & (4'b0001 << idx_d)) : 4'hF;
      seg_d = enable ? hex7(active_d[{idx_d, 2'b00} +: 4]) : 7'h7F;
      digit_sel_d = idx_d;
      frame_done_d = boundary;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= D0;
         active_q <= '0;
         shadow_q <= '0;
         pending_q <= 1'b0;
         anode_q <= 4'hF;
         seg_q <= 7'h7F;
         digit_sel_q <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pending_q <= pending_d;
         anode_q <= anode_d;
         seg_q <= seg_d;
         digit_sel_q <= digit_sel_d;
         frame_done_q <= frame_done_d;
      end
   end
   assign load_ready = ~pending_q;
   assign anode = anode_q;
   assign seg = seg_q;
   assign digit_sel = digit_sel_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed bench with a frame-level model checked every cycle plus literal expectations.
module tb_seven_seg_scan_ctrl;
   localparam int P = 4;
   localparam int B = 1;
`ifdef SEG_GHOST_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, load_valid = 1'b0;
   logic [3:0] digit_mask = 4'hF;
   logic [15:0] load_data = '0;
   logic load_ready, frame_done;
   logic [3:0] anode;
   logic [6:0] seg;
   logic [1:0] digit_sel;
   int checks = 0, errors = 0, n = 0;
   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   seven_seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
      .clk(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
      .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
      .anode(anode), .seg(seg), .digit_sel(digit_sel), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   // model: run = consecutive enabled edges; slot/digit follow by plain division
   int run = 0, m_idx = 0;
   logic m_bnd, m_acc, m_pend = 1'b0;
   logic [15:0] m_active = '0, m_shadow = '0;
   logic [3:0] e_anode = 4'hF;
   logic [6:0] e_seg = 7'h7F;
   logic [1:0] e_sel = '0;
   logic e_fd = 1'b0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         run = 0; m_pend = 1'b0; m_active = '0; m_shadow = '0;
         e_anode = 4'hF; e_seg = 7'h7F; e_sel = '0; e_fd = 1'b0;
      end else begin
         m_bnd = enable && ((run + 1) % (4 * P) == 0);
         m_acc = load_valid && !m_pend;
         if (m_pend && (m_bnd || !enable)) begin
            m_active = m_shadow;
            m_pend = 1'b0;
         end
         if (m_acc) begin
            m_shadow = load_data;
            m_pend = 1'b1;
         end
         run = enable ? run + 1 : 0;
         m_idx = (run / P) % 4;
         e_sel = 2'(m_idx);
         e_fd = m_bnd;
         e_seg = enable ? hex_tab[4'(m_active >> (4 * m_idx))] : 7'h7F;
         e_anode = (enable && digit_mask[m_idx] && !(BLANK_ON && (run % P) < B)) ? ~(4'b0001 << m_idx) : 4'hF;
      end
   end
   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (!reset) begin
         check("model anode", 16'(anode), 16'(e_anode));
         check("model seg", 16'(seg), 16'(e_seg));
         check("model digit_sel", 16'(digit_sel), 16'(e_sel));
         check("model frame_done", 16'(frame_done), 16'(e_fd));
         check("model load_ready", 16'(load_ready), 16'(!m_pend));
      end
   end
   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask
   task automatic wait_fd(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_done && k < 200);
      checks++;
      if (!frame_done) begin
         errors++;
         $display("FAIL wait_fd: frame_done not seen in %0d cycles", k);
      end
   endtask
   initial begin
      cyc(2);
      check("reset anode", 16'(anode), 16'hF);
      check("reset seg", 16'(seg), 16'h7F);
      check("reset digit_sel", 16'(digit_sel), 16'h0);
      check("reset frame_done", 16'(frame_done), 16'h0);
      check("reset load_ready", 16'(load_ready), 16'h1);
      reset = 1'b0;
      enable = 1'b1;
      // T1: plain scan
      wait_fd(n);
      cyc(1); check("t1 anode0", 16'(anode), 16'hE); check("t1 seg0", 16'(seg), 16'h40);
      cyc(4); check("t1 anode1", 16'(anode), 16'hD); check("t1 sel1", 16'(digit_sel), 16'h1);
      cyc(4); check("t1 anode2", 16'(anode), 16'hB);
      cyc(4); check("t1 anode3", 16'(anode), 16'h7); check("t1 sel3", 16'(digit_sel), 16'h3);
      wait_fd(n);
      wait_fd(n); check("t1 frame period", 16'(n), 16'd16);
      cyc(1); check("t1 anode wrap", 16'(anode), 16'hE);
      // T2: load during slot 1, applies at the 3->0 boundary
      cyc(3);
      load_data = 16'h8F10; load_valid = 1'b1;
      cyc(1); load_valid = 1'b0;
      check("t2 ready low", 16'(load_ready), 16'h0);
      cyc(4); check("t2 seg held", 16'(seg), 16'h40);
      wait_fd(n);
      check("t2 seg d0", 16'(seg), 16'h40); check("t2 ready high", 16'(load_ready), 16'h1);
      cyc(5); check("t2 seg d1", 16'(seg), 16'h79);
      cyc(4); check("t2 seg d2", 16'(seg), 16'h0E);
      cyc(4); check("t2 seg d3", 16'(seg), 16'h00);
      // T3: load_valid held across a busy period
      wait_fd(n);
      load_data = 16'h1234; load_valid = 1'b1;
      cyc(1); load_data = 16'h5678;
      check("t3 ready low", 16'(load_ready), 16'h0);
      wait_fd(n);
      check("t3 seg 1234 d0", 16'(seg), 16'h19); check("t3 ready back", 16'(load_ready), 16'h1);
      cyc(1); load_valid = 1'b0;
      check("t3 5678 captured", 16'(load_ready), 16'h0);
      cyc(4); check("t3 seg 1234 d1", 16'(seg), 16'h30);
      wait_fd(n); check("t3 seg 5678 d0", 16'(seg), 16'h00);
      cyc(4); check("t3 seg 5678 d1", 16'(seg), 16'h78);
      // T4: masked digits keep their slots
      wait_fd(n);
      digit_mask = 4'b0101;
      cyc(1); check("t4 anode0", 16'(anode), 16'hE);
      cyc(4); check("t4 anode1", 16'(anode), 16'hF); check("t4 sel1", 16'(digit_sel), 16'h1);
      cyc(4); check("t4 anode2", 16'(anode), 16'hB); check("t4 sel2", 16'(digit_sel), 16'h2);
      cyc(4); check("t4 anode3", 16'(anode), 16'hF); check("t4 sel3", 16'(digit_sel), 16'h3);
      digit_mask = 4'hF;
      // T5: disable at idx 2 with a pending load, then re-enable
      wait_fd(n);
      cyc(8);
      load_data = 16'hABCD; load_valid = 1'b1;
      cyc(1); load_valid = 1'b0; enable = 1'b0;
      cyc(1);
      check("t5 dark anode", 16'(anode), 16'hF); check("t5 dark seg", 16'(seg), 16'h7F);
      check("t5 sel0", 16'(digit_sel), 16'h0); check("t5 load applied", 16'(load_ready), 16'h1);
      enable = 1'b1;
      cyc(1);
      check("t5 reen anode", 16'(anode), 16'hE); check("t5 reen seg", 16'(seg), 16'h21);
      // T6: async reset mid-slot with a pending load
      cyc(2);
      load_data = 16'h1111; load_valid = 1'b1;
      cyc(1); load_valid = 1'b0;
      check("t6 pending", 16'(load_ready), 16'h0);
      #2 reset = 1'b1;
      #1;
      check("t6 async anode", 16'(anode), 16'hF); check("t6 async ready", 16'(load_ready), 16'h1);
      check("t6 async seg", 16'(seg), 16'h7F);
      @(negedge clk) reset = 1'b0;
      wait_fd(n);
      check("t6 seg cleared", 16'(seg), 16'h40); check("t6 ready", 16'(load_ready), 16'h1);
      cyc(5); check("t6 seg d1 cleared", 16'(seg), 16'h40);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
